// File: rtl/spi_frame_writer.sv
// Frame writer behind the SPI receiver: places each pixel byte into one half of a
// double-buffered frame BRAM, checks frame length and publishes the newest good bank.
module spi_frame_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int H_PIXELS   = 320,
    parameter int V_PIXELS   = 240,
    parameter int CNT_WIDTH  = $clog2(H_PIXELS * V_PIXELS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  final_pixel_in,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic [CNT_WIDTH:0]    addr_out,
    output logic                  we_out,
    output logic                  ready_bank_out,
    output logic                  frame_done_out,
    output logic                  frame_error_out,
    output logic [15:0]           frame_count_out,
    output logic [7:0]            error_count_out,
    output logic [1:0]            state_out
);

    localparam int TOTAL = H_PIXELS * V_PIXELS;
    // One extra index bit so the "overrun armed" value TOTAL is representable.
    localparam int IW = CNT_WIDTH + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(TOTAL - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(TOTAL);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           index_q, index_d;
    logic                    wbank_q, wbank_d;
    logic [DATA_WIDTH-1:0]   pixel_d;
    logic [CNT_WIDTH:0]      addr_d;
    logic                    we_d, done_d, err_d, ready_d;
    logic [15:0]             fcnt_d;
    logic [7:0]              ecnt_d, ecnt_sat;

    assign state_out = state_q;
    assign ecnt_sat  = (error_count_out == 8'hFF) ? 8'hFF : error_count_out + 8'd1;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        wbank_d = wbank_q;
        pixel_d = pixel_out;
        addr_d  = addr_out;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ready_d = ready_bank_out;
        fcnt_d  = frame_count_out;
        ecnt_d  = error_count_out;
        case (state_q)
            SYNC, DROP: begin
                if (data_valid_in && final_pixel_in) begin
                    state_d = ACTIVE;
                    index_d = '0;
                end
            end
            ACTIVE: begin
                if (data_valid_in) begin
                    if (index_q == IDX_END) begin
                        // Byte beyond a full frame: flag once, then resync on the next marker.
                        err_d  = 1'b1;
                        ecnt_d = ecnt_sat;
                        if (final_pixel_in) index_d = '0;
                        else                state_d = DROP;
                    end else begin
                        we_d    = 1'b1;
                        pixel_d = data_in;
                        addr_d  = {wbank_q, index_q[CNT_WIDTH-1:0]};
                        if (final_pixel_in) begin
                            index_d = '0;
                            if (index_q == IDX_LAST) begin
                                done_d  = 1'b1;
                                ready_d = wbank_q;
                                wbank_d = ~wbank_q;
                                fcnt_d  = frame_count_out + 16'd1;
                            end else begin
                                err_d  = 1'b1;
                                ecnt_d = ecnt_sat;
                            end
                        end else begin
                            index_d = index_q + IW'(1);
                        end
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= SYNC;
            index_q         <= '0;
            wbank_q         <= 1'b1;
            pixel_out       <= '0;
            addr_out        <= '0;
            we_out          <= 1'b0;
            ready_bank_out  <= 1'b0;
            frame_done_out  <= 1'b0;
            frame_error_out <= 1'b0;
            frame_count_out <= '0;
            error_count_out <= '0;
        end else begin
            state_q         <= state_d;
            index_q         <= index_d;
            wbank_q         <= wbank_d;
            pixel_out       <= pixel_d;
            addr_out        <= addr_d;
            we_out          <= we_d;
            ready_bank_out  <= ready_d;
            frame_done_out  <= done_d;
            frame_error_out <= err_d;
            frame_count_out <= fcnt_d;
            error_count_out <= ecnt_d;
        end
    end

endmodule
